// File: rtl/qed_pkg.sv
// Shared types and constants for the QED duplicate-execution scheduler.
package qed_pkg;

    localparam int               QED_INSTR_W = 32;
    localparam logic [31:0]      QED_NOP     = 32'h00000013;

    typedef enum logic {
        QED_ORIG,
        QED_DUP
    } qed_state_t;

endpackage

// File: rtl/qed_inst_fifo.sv
// Circular instruction queue holding originals until they are replayed as duplicates.
module qed_inst_fifo
    import qed_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = QED_INSTR_W,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; only pointers and count decide
    // which entries are live, so stale data is never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/qed_dup_scheduler.sv
// QED original/duplicate sequencer in front of decode. Define QED_STATS_EN to add
// the saturating qed_checkpoints counter output.
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   qed_enable,
    input  logic                   exec_dup,
    input  logic                   ifu_valid,
    input  logic [QED_INSTR_W-1:0] ifu_instruction,
    input  logic                   core_ready,
    input  logic [QED_INSTR_W-1:0] qed_instruction,
    output logic [QED_INSTR_W-1:0] qic_qimux_instruction,
    output logic [QED_INSTR_W-1:0] final_instruction,
    output logic                   issue_valid,
    output logic                   is_dup,
    output logic                   fetch_stall,
    output logic                   qed_ready
`ifdef QED_STATS_EN
    ,
    output logic [15:0]            qed_checkpoints
`endif
);

    qed_state_t             state;
    logic                   push;
    logic                   pop;
    logic [QED_INSTR_W-1:0] head;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   qed_mode;
    logic                   go_dup;

    qed_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (QED_INSTR_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (ifu_instruction),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A non-empty queue keeps QED mode alive so a qed_enable drop waits for the drain.
    assign qed_mode = qed_enable | ~empty;

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        issue_valid       = 1'b0;
        final_instruction = QED_NOP;
        is_dup            = 1'b0;
        fetch_stall       = 1'b0;
        push              = 1'b0;
        pop               = 1'b0;
        if (!rst_n) begin
            // Hold reset values on the outputs while reset is asserted.
        end else if (state == QED_DUP) begin
            issue_valid       = 1'b1;
            final_instruction = qed_instruction;
            is_dup            = 1'b1;
            fetch_stall       = 1'b1;
            pop               = core_ready;
        end else if (!qed_mode) begin
            issue_valid       = ifu_valid;
            final_instruction = ifu_instruction;
        end else begin
            issue_valid       = ifu_valid & ~full;
            final_instruction = ifu_instruction;
            fetch_stall       = full;
            push              = ifu_valid & ~full & core_ready;
        end
    end

    assign go_dup = (exec_dup & (~empty | push)) |
                    ((count + CNT_W'(push)) == CNT_W'(DEPTH));

    assign qic_qimux_instruction = (rst_n && !empty) ? head : '0;
    assign qed_ready             = ~rst_n | ((state == QED_ORIG) & empty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= QED_ORIG;
`ifdef QED_STATS_EN
            qed_checkpoints <= '0;
`endif
        end else begin
            case (state)
                QED_ORIG: if (qed_mode && go_dup) state <= QED_DUP;
                QED_DUP: begin
                    if (pop && count == CNT_W'(1)) begin
                        state <= QED_ORIG;
`ifdef QED_STATS_EN
                        if (qed_checkpoints != 16'hFFFF)
                            qed_checkpoints <= qed_checkpoints + 16'd1;
`endif
                    end
                end
                default: state <= QED_ORIG;
            endcase
        end
    end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Directed self-checking bench for qed_dup_scheduler (DEPTH = 16).
module tb_qed_dup_scheduler;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        qed_enable;
    logic        exec_dup;
    logic        ifu_valid;
    logic [31:0] ifu_instruction;
    logic        core_ready;
    logic [31:0] qed_instruction;
    logic [31:0] qic_qimux_instruction;
    logic [31:0] final_instruction;
    logic        issue_valid;
    logic        is_dup;
    logic        fetch_stall;
    logic        qed_ready;
`ifdef QED_STATS_EN
    logic [15:0] qed_checkpoints;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qed_dup_scheduler #(.DEPTH(16), .CNT_W(5)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .qed_enable            (qed_enable),
        .exec_dup              (exec_dup),
        .ifu_valid             (ifu_valid),
        .ifu_instruction       (ifu_instruction),
        .core_ready            (core_ready),
        .qed_instruction       (qed_instruction),
        .qic_qimux_instruction (qic_qimux_instruction),
        .final_instruction     (final_instruction),
        .issue_valid           (issue_valid),
        .is_dup                (is_dup),
        .fetch_stall           (fetch_stall),
        .qed_ready             (qed_ready)
`ifdef QED_STATS_EN
        ,
        .qed_checkpoints       (qed_checkpoints)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so the next inputs and checks land mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] orig3 [3];
    int          stall_cycles;
    int          idx;

    initial begin
        orig3[0] = 32'h00100093;
        orig3[1] = 32'h00200113;
        orig3[2] = 32'h00308193;

        rst_n = 1'b0; qed_enable = 1'b0; exec_dup = 1'b0; ifu_valid = 1'b0;
        ifu_instruction = NOP; core_ready = 1'b0; qed_instruction = 32'hDEAD0000;
        tick(); tick();
        check("rst_qed_ready",   32'(qed_ready),   32'd1);
        check("rst_final",       final_instruction, NOP);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_fetch_stall", 32'(fetch_stall), 32'd0);
        check("rst_is_dup",      32'(is_dup),      32'd0);
        check("rst_qic",         qic_qimux_instruction, 32'd0);

        // 1: out of reset, QED on, idle fetch
        rst_n = 1'b1; qed_enable = 1'b1; core_ready = 1'b1;
        tick();
        check("t1_qed_ready",   32'(qed_ready),   32'd1);
        check("t1_final",       final_instruction, NOP);
        check("t1_fetch_stall", 32'(fetch_stall), 32'd0);

        // 2: three originals, exec_dup alongside the third push
        for (int i = 0; i < 3; i++) begin
            ifu_valid = 1'b1; ifu_instruction = orig3[i]; exec_dup = (i == 2);
            #1;
            check("t2_orig_valid", 32'(issue_valid), 32'd1);
            check("t2_orig_final", final_instruction, orig3[i]);
            check("t2_orig_isdup", 32'(is_dup), 32'd0);
            tick();
        end
        ifu_valid = 1'b0; exec_dup = 1'b0;
        for (int i = 0; i < 3; i++) begin
            qed_instruction = 32'h80000000 | 32'(i);
            #1;
            check("t2_dup_isdup", 32'(is_dup), 32'd1);
            check("t2_dup_qic",   qic_qimux_instruction, orig3[i]);
            check("t2_dup_stall", 32'(fetch_stall), 32'd1);
            check("t2_dup_final", final_instruction, 32'h80000000 | 32'(i));
            check("t2_dup_ready", 32'(qed_ready), 32'd0);
            tick();
        end
        check("t2_end_ready", 32'(qed_ready), 32'd1);
        check("t2_end_isdup", 32'(is_dup), 32'd0);
        check("t2_end_stall", 32'(fetch_stall), 32'd0);

        // 3: sixteen originals, full queue forces DUP
        for (int i = 0; i < 16; i++) begin
            ifu_valid = 1'b1; ifu_instruction = 32'h10000000 + 32'(i);
            #1;
            check("t3_push_stall", 32'(fetch_stall), 32'd0);
            check("t3_push_valid", 32'(issue_valid), 32'd1);
            tick();
        end
        ifu_valid = 1'b0;
        stall_cycles = 0;
        idx = 0;
        for (int k = 0; k < 40 && fetch_stall; k++) begin
            check("t3_dup_qic",   qic_qimux_instruction, 32'h10000000 + 32'(idx));
            check("t3_dup_isdup", 32'(is_dup), 32'd1);
            idx++;
            stall_cycles++;
            tick();
        end
        check("t3_stall_cycles", 32'(stall_cycles), 32'd16);
        check("t3_end_ready",    32'(qed_ready), 32'd1);

        // 4: decode back-pressure during DUP
        ifu_valid = 1'b1; ifu_instruction = 32'h00400213; tick();
        ifu_instruction = 32'h00500293; exec_dup = 1'b1; tick();
        ifu_valid = 1'b0; exec_dup = 1'b0; core_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t4_hold_qic",   qic_qimux_instruction, 32'h00400213);
            check("t4_hold_isdup", 32'(is_dup), 32'd1);
            tick();
        end
        check("t4_still_dup", 32'(is_dup), 32'd1);
        core_ready = 1'b1;
        check("t4_drain0_qic", qic_qimux_instruction, 32'h00400213);
        tick();
        check("t4_drain1_qic", qic_qimux_instruction, 32'h00500293);
        tick();
        check("t4_end_ready", 32'(qed_ready), 32'd1);
        check("t4_end_isdup", 32'(is_dup), 32'd0);

        // 5: exec_dup with nothing to replay is ignored
        exec_dup = 1'b1; ifu_valid = 1'b0; tick();
        exec_dup = 1'b0;
        check("t5_ready", 32'(qed_ready), 32'd1);
        check("t5_isdup", 32'(is_dup), 32'd0);
        check("t5_stall", 32'(fetch_stall), 32'd0);

        // passthrough: no pushes with QED off
        qed_enable = 1'b0; ifu_valid = 1'b1; ifu_instruction = 32'h00600313; exec_dup = 1'b1;
        #1;
        check("pt_final", final_instruction, 32'h00600313);
        check("pt_valid", 32'(issue_valid), 32'd1);
        tick();
        ifu_valid = 1'b0; exec_dup = 1'b0;
        check("pt_ready", 32'(qed_ready), 32'd1);
        check("pt_qic",   qic_qimux_instruction, 32'd0);
        check("pt_isdup", 32'(is_dup), 32'd0);

        // 6: reset in DUP with five entries queued
        qed_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifu_valid = 1'b1; ifu_instruction = 32'h20000000 + 32'(i); exec_dup = (i == 4);
            tick();
        end
        ifu_valid = 1'b0; exec_dup = 1'b0; core_ready = 1'b0;
        check("t6_in_dup", 32'(is_dup), 32'd1);
`ifdef QED_STATS_EN
        check("t6_ckpt_before", 32'(qed_checkpoints), 32'd3);
`endif
        rst_n = 1'b0; tick();
        rst_n = 1'b1; core_ready = 1'b1;
        #1;
        check("t6_ready", 32'(qed_ready), 32'd1);
        check("t6_qic",   qic_qimux_instruction, 32'd0);
        check("t6_isdup", 32'(is_dup), 32'd0);
`ifdef QED_STATS_EN
        check("t6_ckpt", 32'(qed_checkpoints), 32'd0);
`endif
        tick();
        check("t6_no_drain", 32'(qed_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
